// File: rtl/block_interleaver.sv
// Ping-pong block interleaver/deinterleaver: one bank fills with the current
// block in natural order while the other is read out in permuted order.
module block_interleaver #(
  parameter int W    = 1,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         mode,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         sof_o
);

  localparam int N  = ROWS * COLS;
  localparam int KW = $clog2(N);

  logic [KW-1:0] k_p0;
  logic          bank_p0;
  logic          primed_p0;
  logic          mode_lat_p0;

  logic [W-1:0]  mem [2][N];

  logic          acc;
  logic          k_first;
  logic          k_last;
  logic          mode_rd;
  logic [KW-1:0] rd_addr;

  // Row-major write, column-major read for interleave; transpose for deinterleave.
  function automatic logic [KW-1:0] perm_addr(input logic [KW-1:0] kk, input logic m);
    int ki;
    ki = int'(kk);
    if (m)
      return KW'((ki % COLS) * ROWS + ki / COLS);
    else
      return KW'((ki % ROWS) * COLS + ki / ROWS);
  endfunction

  always_comb begin
    acc     = valid_i & ~clr;
    k_first = (k_p0 == '0);
    k_last  = (k_p0 == KW'(N - 1));
    // The first sample of a block uses the incoming mode, the rest the latched one.
    mode_rd = k_first ? mode : mode_lat_p0;
    rd_addr = perm_addr(k_p0, mode_rd);
  end

  always_ff @(posedge clk) begin
    if (acc)
      mem[bank_p0][k_p0] <= data_i;
  end

  // Stage p0 -> output: control advance and registered read of the other bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_p0        <= '0;
      bank_p0     <= 1'b0;
      primed_p0   <= 1'b0;
      mode_lat_p0 <= 1'b0;
      valid_o     <= 1'b0;
      sof_o       <= 1'b0;
      data_o      <= '0;
    end else if (clr) begin
      k_p0      <= '0;
      bank_p0   <= 1'b0;
      primed_p0 <= 1'b0;
      valid_o   <= 1'b0;
      sof_o     <= 1'b0;
    end else if (valid_i) begin
      if (k_first)
        mode_lat_p0 <= mode;
      valid_o <= primed_p0;
      sof_o   <= primed_p0 & k_first;
      if (primed_p0)
        data_o <= mem[~bank_p0][rd_addr];
      if (k_last) begin
        k_p0      <= '0;
        bank_p0   <= ~bank_p0;
        primed_p0 <= 1'b1;
      end else begin
        k_p0 <= k_p0 + KW'(1);
      end
    end else begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_interleaver.sv
// Bench for block_interleaver: a 2x3 byte instance driven by a cycle model
// and scoreboard, plus a default 4x4 interleaver->deinterleaver chain.
module tb_block_interleaver;

  localparam int R  = 2;
  localparam int C  = 3;
  localparam int N6 = R * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       mode = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_o;
  logic [7:0] data_o;
  logic       sof_o;

  logic       c_vi = 1'b0;
  logic [0:0] c_di = '0;
  logic       il_vo, il_sof, dl_vo, dl_sof;
  logic [0:0] il_do, dl_do;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] d;
  } exp_t;
  exp_t sb_q[$];
  logic chain_q[$];
  bit   chain_on = 1'b0;
  int   chain_idx = 0;

  int         mk;
  bit         mprimed;
  bit         mmode;
  logic [7:0] mcur  [N6];
  logic [7:0] mprev [N6];
  logic [7:0] mlast;

  always #5 clk = ~clk;

  block_interleaver #(.W(8), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .valid_i(valid_i),
    .data_i(data_i), .valid_o(valid_o), .data_o(data_o), .sof_o(sof_o)
  );

  block_interleaver il (
    .clk(clk), .rst(rst), .clr(1'b0), .mode(1'b0), .valid_i(c_vi),
    .data_i(c_di), .valid_o(il_vo), .data_o(il_do), .sof_o(il_sof)
  );

  block_interleaver dl (
    .clk(clk), .rst(rst), .clr(1'b0), .mode(1'b1), .valid_i(il_vo),
    .data_i(il_do), .valid_o(dl_vo), .data_o(dl_do), .sof_o(dl_sof)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int perm(input int kk, input bit m);
    return m ? (kk % C) * R + kk / C : (kk % R) * C + kk / R;
  endfunction

  task automatic model_reset();
    mk = 0; mprimed = 1'b0; mmode = 1'b0; mlast = '0;
    sb_q.delete();
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic m, input logic c);
    exp_t e;
    exp_t got;
    bit   mu;
    clr = c; valid_i = v; data_i = d; mode = m;
    e.v = 1'b0; e.s = 1'b0; e.d = mlast;
    if (c) begin
      mk = 0; mprimed = 1'b0;
    end else if (v) begin
      mu = (mk == 0) ? m : mmode;
      if (mk == 0) mmode = m;
      if (mprimed) begin
        e.v = 1'b1; e.s = (mk == 0); e.d = mprev[perm(mk, mu)]; mlast = e.d;
      end
      mcur[mk] = d;
      if (mk == N6 - 1) begin
        mprev = mcur; mk = 0; mprimed = 1'b1;
      end else begin
        mk++;
      end
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    got = sb_q.pop_front();
    chk("valid_o", 32'(valid_o), 32'(got.v));
    chk("sof_o", 32'(sof_o), 32'(got.s));
    chk("data_o", 32'(data_o), 32'(got.d));
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; clr = 1'b0; valid_i = 1'b0; mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid_o", 32'(valid_o), 32'(0));
    chk("rst_sof_o", 32'(sof_o), 32'(0));
    chk("rst_data_o", 32'(data_o), 32'(0));
    rst = 1'b1;
    model_reset();
  endtask

  task automatic run27();
    logic [7:0] exp27 [6];
    exp27 = '{8'd0, 8'd3, 8'd1, 8'd4, 8'd2, 8'd5};
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i >= 6) begin
        chk("r27_data", 32'(data_o), 32'(exp27[i-6]));
        chk("r27_sof", 32'(sof_o), 32'(i == 6));
      end
    end
  endtask

  always @(negedge clk) begin
    if (chain_on && dl_vo) begin
      checks++;
      assert (chain_q.size() > 0) else begin
        errors++;
        $error("FAIL chain_extra observed output expected none (queue empty)");
      end
      if (chain_q.size() > 0) begin
        chk("chain_bit", 32'(dl_do), 32'(chain_q.pop_front()));
        chk("chain_sof", 32'(dl_sof), 32'(chain_idx % 16 == 0));
        chain_idx++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seq28 [6];
    logic [7:0] exp28 [6];
    logic       m;
    int         g;
    seq28 = '{8'd0, 8'd3, 8'd1, 8'd4, 8'd2, 8'd5};
    exp28 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};

    do_reset();
    run27();

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, (i < 6) ? seq28[i] : 8'hA5, 1'b1, 1'b0);
      if (i >= 6) chk("r28_data", 32'(data_o), 32'(exp28[i-6]));
    end

    // Gapped traffic with a mode change in the middle of block 1
    do_reset();
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < N6; s++) begin
        m = (b == 1 && s >= 3) || (b == 2);
        if (s % 2 == 1) step(1'b0, 8'h5A, m, 1'b0);
        step(1'b1, 8'($urandom), m, 1'b0);
      end
    end

    // Clear at k=4 of block 2, then resume
    do_reset();
    for (int i = 0; i < 2 * N6 + 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 3 * N6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);

    // Asynchronous reset mid-block while output is active
    for (int i = 0; i < 2; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("async_valid_o", 32'(valid_o), 32'(0));
    chk("async_sof_o", 32'(sof_o), 32'(0));
    chk("async_data_o", 32'(data_o), 32'(0));
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run27();
    valid_i = 1'b0;

    // Default-size interleaver chained into deinterleaver with random gaps
    chain_on = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int s = 0; s < 16; s++) begin
        g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) begin
          c_vi = 1'b0;
          @(posedge clk); #1;
          chk("gap_valid_o", 32'(il_vo), 32'(0));
        end
        c_vi = 1'b1;
        c_di = 1'($urandom);
        chain_q.push_back(c_di[0]);
        @(posedge clk); #1;
      end
    end
    c_vi = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("chain_remaining", 32'(chain_q.size()), 32'(32));
    chk("chain_outputs", 32'(chain_idx), 32'(64));
    chain_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_interleaver.md
BLOCK_INTERLEAVER -- requirements
Module: block_interleaver

Interface
REQ-001 Parameter W, default 1: data symbol width in bits.
REQ-002 Parameter ROWS, default 4: matrix row count; legal range 2..64.
REQ-003 Parameter COLS, default 4: matrix column count; legal range 2..64. Block length N = ROWS*COLS.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous clear of block state; priority over valid_i.
REQ-007 mode  input  1  0 = interleave, 1 = deinterleave.
REQ-008 valid_i  input  1  data_i holds an accepted symbol this cycle.
REQ-009 data_i  input  W  input symbol.
REQ-010 valid_o  output  1  data_o holds an output symbol this cycle.
REQ-011 data_o  output  W  output symbol.
REQ-012 sof_o  output  1  pulses high with the first output symbol of each block.

Function
REQ-013 Two banks of N symbols SHALL operate ping-pong: one bank is written by the current block while the other is read for the previous block.
REQ-014 Sample counter k SHALL advance 0..N-1 only on cycles with valid_i=1; at k=N-1 it SHALL wrap to 0 and toggle the bank select.
REQ-015 Accepted symbol k SHALL be written to address k of the write bank.
REQ-016 On the same accepted cycle, the read bank address SHALL be (k%ROWS)*COLS + k/ROWS in interleave mode and (k%COLS)*ROWS + k/COLS in deinterleave mode (integer division).
REQ-017 The read symbol SHALL appear on data_o with valid_o=1 exactly one cycle after the accepting edge (latency: 1 cycle plus N accepted samples).
REQ-018 An internal primed flag SHALL be set when the first block completes; while primed=0, valid_o SHALL stay 0.
REQ-019 sof_o SHALL be 1 only in the cycle valid_o=1 is caused by k=0; otherwise 0.
REQ-020 mode SHALL be latched only when an accepted sample has k=0; a mode change mid-block SHALL take effect at the next block start. The latched mode governs reads of the block whose first sample latched it.
REQ-021 Cycles with valid_i=0 SHALL hold k, banks and bank select; valid_o and sof_o SHALL be 0 in the following cycle, and data_o SHALL hold its last value.
REQ-022 Write and read in the same cycle SHALL always target different banks; no bypass path is required.
REQ-023 clr=1 SHALL zero k, bank select and primed, and force valid_o=0 and sof_o=0 next cycle. Bank contents are don't-care. The symbol on data_i in that cycle SHALL be discarded.
REQ-024 Counter width SHALL be clog2(N); no arithmetic overflow is permitted at k=N-1.

Reset
REQ-025 While rst=0: valid_o=0, sof_o=0, data_o=0, k=0, bank select=0, primed=0, latched mode=0. Bank memory need not be reset.
REQ-026 After rst rises, the first accepted sample SHALL be k=0 of block 0. Reset mid-block SHALL abandon that block and the primed data.

Verification
REQ-027 ROWS=2, COLS=3, W=8, mode=0, continuous valid_i, inputs 0..11 -> no valid_o for the first 6 samples; then data_o = 0,3,1,4,2,5 with sof_o on the first value.
REQ-028 Same parameters, mode=1, input 0,3,1,4,2,5,x,x,x,x,x,x -> second-block outputs 0,1,2,3,4,5.
REQ-029 Defaults (4x4, W=1), random valid_i gaps of 0..3 cycles, interleaver chained into deinterleaver -> bitstream recovered exactly after 2N accepted samples; valid_o=0 in every gap cycle.
REQ-030 Toggle mode at k=7 of block 1 -> block 1 reads still use the mode latched at its k=0; the new mode applies to the next block.
REQ-031 Assert clr at k=9 of block 2, then resume -> no valid_o for the next N accepted samples, then correct permuted output with sof_o.
REQ-032 Drop rst low mid-block with valid_i=1 -> all outputs 0 immediately (asynchronously); after release, behaviour matches REQ-027 from a fresh start.
